// File: rtl/jesd_tx_pkg.sv
// Shared types and constants for the JESD204 TX LMFC / frame-boundary logic.
package jesd_tx_pkg;

    // SYSREF handling modes; the reserved encoding 3 decodes to FREERUN.
    typedef enum logic [1:0] {
        ONESHOT    = 2'd0,
        CONTINUOUS = 2'd1,
        FREERUN    = 2'd2
    } sysref_mode_e;

    localparam int unsigned MPOS_W = 10;
    // Reset configuration: 4 octets per frame, 8 frames per multiframe.
    localparam logic [3:0] DEF_F = 4'd3;
    localparam logic [4:0] DEF_K = 5'd7;

    // Multiframe length in octets, (F+1)*(K+1); at most 512 so fits MPOS_W.
    function automatic logic [MPOS_W-1:0] fk_calc(input logic [3:0] f, input logic [4:0] k);
        logic [MPOS_W-1:0] a;
        logic [MPOS_W-1:0] b;
        a = MPOS_W'(f) + MPOS_W'(1);
        b = MPOS_W'(k) + MPOS_W'(1);
        return a * b;
    endfunction

    function automatic sysref_mode_e mode_decode(input logic [1:0] m);
        case (m)
            2'd0:    return ONESHOT;
            2'd1:    return CONTINUOUS;
            default: return FREERUN;
        endcase
    endfunction

endpackage

// File: rtl/tx_sysref_det.sv
// SYSREF rising-edge detector followed by a programmable delay line.
// The event fires SYSREF_DLY enabled cycles after the edge (0 = same cycle).
// DLY_W must be at least 2 so the line holds two or more stages.
module tx_sysref_det #(
    parameter int unsigned DLY_W = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             EN,
    input  logic             SYSREF,
    input  logic [DLY_W-1:0] SYSREF_DLY,
    output logic             EVENT
);

    localparam int unsigned DEPTH = (1 << DLY_W) - 1;

    logic             sysref_q;
    logic [DEPTH-1:0] dly_q;
    logic             edge_s;
    logic             tap;

    assign edge_s = EN & SYSREF & ~sysref_q;

    // Previous SYSREF level and delay line; both freeze while EN is low.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sysref_q <= 1'b0;
            dly_q    <= '0;
        end else if (EN) begin
            sysref_q <= SYSREF;
            dly_q    <= {dly_q[DEPTH-2:0], edge_s};
        end
    end

    // Select the tap; stage j holds the edge from j+1 enabled cycles ago.
    always_comb begin
        tap = edge_s;
        if (SYSREF_DLY != '0) begin
            tap = dly_q[SYSREF_DLY - DLY_W'(1)];
        end
    end

    assign EVENT = tap & EN;

endmodule

// File: rtl/tx_lmfc_gen.sv
// LMFC and frame-boundary generator for the JESD204 TX datapath.
// Produces per-octet frame/multiframe start/end markers for BYTES octets per
// clock, with SYSREF alignment, phase monitoring and configuration checking.
module tx_lmfc_gen
    import jesd_tx_pkg::*;
#(
    parameter int unsigned BYTES = 4,
    parameter int unsigned DLY_W = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              EN,
    input  logic              SYSREF,
    input  logic              LOAD_SETUP,
    input  logic [7:0]        F,
    input  logic [4:0]        K,
    input  logic [1:0]        SYSREF_MODE,
    input  logic [DLY_W-1:0]  SYSREF_DLY,
    input  logic              REARM,
    output logic [BYTES-1:0]  MS,
    output logic [BYTES-1:0]  ME,
    output logic [BYTES-1:0]  FS,
    output logic [BYTES-1:0]  FE,
    output logic [9:0]        LMFC_CNT,
    output logic              SYNCED,
    output logic              PHASE_ERR,
    output logic              CFG_ERR
);

    localparam int unsigned        SHIFT   = $clog2(BYTES);
    localparam logic [MPOS_W-1:0]  STEP    = MPOS_W'(BYTES);
    localparam logic [5:0]         STEP6   = 6'(BYTES);
    localparam logic [MPOS_W-1:0]  FK_MASK = MPOS_W'(BYTES - 1);

    // Small modulo by repeated conditional subtraction. Operands never exceed
    // (F+1)+BYTES-1, so BYTES+1 steps always suffice even for F+1 = 1.
    function automatic logic [5:0] mod_small(input logic [5:0] v, input logic [5:0] m);
        logic [5:0] r;
        r = v;
        for (int unsigned s = 0; s <= BYTES; s++) begin
            if (r >= m) begin
                r = r - m;
            end
        end
        return r;
    endfunction

    // Active configuration
    logic [3:0]        cfg_f_q, cfg_f_d;
    logic [MPOS_W-1:0] cfg_fk_q, cfg_fk_d;
    sysref_mode_e      cfg_mode_q, cfg_mode_d;
    logic              cfg_err_q, cfg_err_d;

    // Staged configuration awaiting its legality check
    logic              load_q;
    logic              chk_q;
    logic [7:0]        stg_f_q;
    logic [MPOS_W-1:0] stg_fk_q;
    sysref_mode_e      stg_mode_q;
    logic              load_rise;
    logic              stg_legal;

    // Position counters and alignment status
    logic [MPOS_W-1:0] mpos_q, mpos_d;
    logic [3:0]        fpos_q, fpos_d;
    logic              synced_q, synced_d;
    logic              phase_err_q, phase_err_d;

    logic [MPOS_W-1:0] mpos_last;
    logic [MPOS_W-1:0] mpos_adv;
    logic [3:0]        fpos_adv;
    logic [5:0]        fmod;
    logic              aligned;
    logic              sys_event;
    logic              synced_eff;
    logic              realign;
    logic [5:0]        idx;

    tx_sysref_det #(
        .DLY_W (DLY_W)
    ) u_sysref_det (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .EN         (EN),
        .SYSREF     (SYSREF),
        .SYSREF_DLY (SYSREF_DLY),
        .EVENT      (sys_event)
    );

    assign load_rise = LOAD_SETUP & ~load_q;
    // F above 15 is out of range; FK must hold a whole number of words.
    assign stg_legal = (stg_f_q[7:4] == 4'd0) && ((stg_fk_q & FK_MASK) == '0);

    assign fmod      = 6'(cfg_f_q) + 6'd1;
    assign mpos_last = cfg_fk_q - STEP;
    assign aligned   = (mpos_q == mpos_last);
    assign mpos_adv  = aligned ? '0 : mpos_q + STEP;
    assign fpos_adv  = 4'(mod_small(6'(fpos_q) + STEP6, fmod));

    // Capture F/K/mode on a LOAD_SETUP rising edge, independent of EN.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            load_q     <= 1'b0;
            chk_q      <= 1'b0;
            stg_f_q    <= '0;
            stg_fk_q   <= '0;
            stg_mode_q <= ONESHOT;
        end else begin
            load_q <= LOAD_SETUP;
            chk_q  <= load_rise;
            if (load_rise) begin
                stg_f_q    <= F;
                stg_fk_q   <= fk_calc(F[3:0], K);
                stg_mode_q <= mode_decode(SYSREF_MODE);
            end
        end
    end

    // Next state: a legal config apply overrides counting and SYSREF handling.
    always_comb begin
        cfg_f_d     = cfg_f_q;
        cfg_fk_d    = cfg_fk_q;
        cfg_mode_d  = cfg_mode_q;
        cfg_err_d   = cfg_err_q;
        mpos_d      = mpos_q;
        fpos_d      = fpos_q;
        synced_d    = synced_q;
        phase_err_d = phase_err_q;
        synced_eff  = 1'b0;
        realign     = 1'b0;

        if (chk_q && stg_legal) begin
            cfg_f_d     = stg_f_q[3:0];
            cfg_fk_d    = stg_fk_q;
            cfg_mode_d  = stg_mode_q;
            cfg_err_d   = 1'b0;
            mpos_d      = '0;
            fpos_d      = '0;
            synced_d    = 1'b0;
            phase_err_d = 1'b0;
        end else begin
            if (chk_q) begin
                cfg_err_d = 1'b1;
            end
            if (EN) begin
                // REARM takes effect before any event in the same cycle.
                synced_eff = synced_q & ~REARM;
                synced_d   = synced_eff;
                if (REARM) begin
                    phase_err_d = 1'b0;
                end
                case (cfg_mode_q)
                    ONESHOT: begin
                        if (sys_event) begin
                            if (!synced_eff) begin
                                realign  = 1'b1;
                                synced_d = 1'b1;
                            end else if (!aligned) begin
                                phase_err_d = 1'b1;
                            end
                        end
                    end
                    CONTINUOUS: begin
                        if (sys_event) begin
                            realign  = 1'b1;
                            synced_d = 1'b1;
                            if (synced_eff && !aligned) begin
                                phase_err_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        synced_d = 1'b0;
                    end
                endcase
                mpos_d = realign ? '0 : mpos_adv;
                fpos_d = realign ? '0 : fpos_adv;
            end
        end
    end

    // Configuration, counters and status registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cfg_f_q     <= DEF_F;
            cfg_fk_q    <= fk_calc(DEF_F, DEF_K);
            cfg_mode_q  <= ONESHOT;
            cfg_err_q   <= 1'b0;
            mpos_q      <= '0;
            fpos_q      <= '0;
            synced_q    <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            cfg_f_q     <= cfg_f_d;
            cfg_fk_q    <= cfg_fk_d;
            cfg_mode_q  <= cfg_mode_d;
            cfg_err_q   <= cfg_err_d;
            mpos_q      <= mpos_d;
            fpos_q      <= fpos_d;
            synced_q    <= synced_d;
            phase_err_q <= phase_err_d;
        end
    end

    // Per-octet markers decoded from the lane-0 frame and multiframe offsets.
    always_comb begin
        MS  = '0;
        ME  = '0;
        FS  = '0;
        FE  = '0;
        idx = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            idx   = mod_small(6'(fpos_q) + 6'(i), fmod);
            FS[i] = (idx == 6'd0);
            FE[i] = (idx == 6'(cfg_f_q));
        end
        MS[0]       = (mpos_q == '0);
        ME[BYTES-1] = aligned;
    end

    assign LMFC_CNT  = 10'(mpos_q >> SHIFT);
    assign SYNCED    = synced_q;
    assign PHASE_ERR = phase_err_q;
    assign CFG_ERR   = cfg_err_q;

endmodule

// File: doc/tx_lmfc_gen.md
Name: tx_lmfc_gen

Overview:
Parametrised local-multiframe clock (LMFC) and frame-boundary generator for the JESD204 TX datapath, processing BYTES octets per lane per clock. Supports any F in 1..16 and K in 1..32, provided F*K is a multiple of BYTES. Provides per-octet frame and multiframe start/end markers to the lane framers and ILAS sequencer. Adds selectable SYSREF handling (one-shot, continuous, free-run), programmable SYSREF delay, phase-error monitoring and configuration validation.

Parameters:
BYTES, 4, octets per clock per lane; legal values 1, 2, 4, 8.
DLY_W, 4, width of SYSREF_DLY; delay line depth is 2^DLY_W-1.

Ports:
CLK  in  1  datapath clock.
RST_n  in  1  reset; asynchronous, active-low.
EN  in  1  clock enable; when low, all state holds.
SYSREF  in  1  SYSREF, already synchronous to CLK.
LOAD_SETUP  in  1  rising edge captures F, K and SYSREF_MODE.
F  in  8  octets per frame minus 1; legal 0..15.
K  in  5  frames per multiframe minus 1.
SYSREF_MODE  in  2  0 one-shot, 1 continuous, 2 free-run, 3 reserved (treated as 2).
SYSREF_DLY  in  DLY_W  SYSREF event delay in cycles; sampled live.
REARM  in  1  single-cycle pulse; clears SYNCED and PHASE_ERR and re-enables one-shot alignment.
MS, ME, FS, FE  out  BYTES  multiframe/frame start/end per octet; bit i is octet i, bit 0 the earliest.
LMFC_CNT  out  10  word index within the multiframe (mpos/BYTES).
SYNCED  out  1  LMFC aligned to SYSREF.
PHASE_ERR  out  1  sticky: a SYSREF event arrived off LMFC phase.
CFG_ERR  out  1  last load was illegal.

Behaviour:
- Reset values: F=4, K=8, mode 0. mpos=0, fpos=0. SYNCED, PHASE_ERR and CFG_ERR are 0; MS[0]=1 and FS/FE follow from that state.
- Internal counters:
  - mpos is the octet offset of lane 0 within the multiframe (10 bits). It advances by BYTES modulo FK=(F+1)*(K+1).
  - fpos is the octet offset of lane 0 within the frame. It advances to (fpos+BYTES) mod (F+1).
  - Both advance only when EN=1.
- Marker outputs, purely combinational from registers:
  - Octet i has frame index idx_i=(fpos+i) mod (F+1).
  - FS[i] is high when idx_i=0; FE[i] is high when idx_i=F.
  - MS[0] is high when mpos=0; ME[BYTES-1] is high when mpos=FK-BYTES. All other MS/ME bits are 0.
- Configuration load:
  - Cycle 1: a LOAD_SETUP 0->1 edge is detected regardless of EN.
  - Cycle 2: FK is registered and checked. If FK mod BYTES != 0, CFG_ERR=1 and the previous configuration is retained with no counter reset.
  - If legal: CFG_ERR=0, the new configuration is applied, mpos=fpos=0, and SYNCED and PHASE_ERR are cleared.
- SYSREF path (sub-module):
  - edge = EN & SYSREF & ~sysref_d, where sysref_d updates only when EN=1.
  - edge passes through a shift register with tap SYSREF_DLY, so the event fires SYSREF_DLY enabled cycles after the edge. DLY=0 means the same cycle.
- Event handling. "Aligned" means the event cycle has mpos=FK-BYTES.
  - Mode 0: if SYNCED=0, the event forces mpos=fpos=0 on the next cycle and sets SYNCED. If SYNCED=1, the event only checks phase.
  - Mode 1: every event realigns. If SYNCED=1 and the event is not aligned, PHASE_ERR is set.
  - Mode 2: events are ignored, SYNCED=0 and the counters free-run.
- Simultaneous events:
  - REARM and an event in the same cycle: REARM clears first, then the event aligns, so SYNCED=1 on the next cycle.
  - A config apply and an event in the same cycle: the config apply wins.
- Asynchronous reset mid-operation returns everything to reset values immediately, including the delay line.

Decomposition:
- Package jesd_tx_pkg holds:
  - sysref_mode_e enum (ONESHOT, CONTINUOUS, FREERUN);
  - localparams MPOS_W=10, DEF_F=3, DEF_K=7.
- Sub-module tx_sysref_det (edge detect plus delay line, parameter DLY_W) outputs a single-cycle event.
- Frame-index modulo uses bounded conditional subtraction: at most ceil((15+BYTES)/1) steps, unrolled to BYTES+1 compares.

Test Plan:
1. BYTES=4, reset defaults, EN=1, no SYSREF -> MS=0001 every 8 cycles; ME=1000 one cycle before each; FS=0001 and FE=1000 every cycle; LMFC_CNT 0..7; SYNCED=0.
2. Load F=2, K=3 (FK=12) -> period 3; FS/FE cycle through 1001/0100, 0100/0010, 0010/1001; CFG_ERR=0.
3. Load F=2, K=4 (FK=15) -> CFG_ERR=1; previous 12-octet pattern continues uninterrupted.
4. Mode 0, DLY=2, SYSREF edge at cycle t with LMFC_CNT=5 -> LMFC_CNT=0 and SYNCED=1 at t+3. Second edge off-phase -> no realign, PHASE_ERR=1. REARM then edge -> realign, PHASE_ERR=0.
5. Mode 1, periodic SYSREF every 8 cycles landing on ME cycles -> no counter disturbance, PHASE_ERR=0. One edge shifted by +1 cycle -> realign and PHASE_ERR=1.
6. EN low for 5 cycles at LMFC_CNT=3 -> outputs frozen, resumes at 4. RST_n low mid-delay -> pending SYSREF event discarded, outputs at reset values.
